// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction-fetch stage
package if_pkg;

   typedef enum logic [1:0] {
      SEL_SEQ,
      SEL_BR,
      SEL_J,
      SEL_JR
   } redir_sel_t;

   localparam int unsigned PC_STEP          = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_fifo.sv
// rtl/if_fetch_fifo.sv - synchronous FIFO holding fetched {instr, pc, pc+4} entries
// Flush has priority over push/pop; a pop on an empty queue is ignored.
module if_fetch_fifo
   import if_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 96
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: the read port is masked while the queue is empty.
   always_ff @(posedge clk) begin
      if (do_push && !reset && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - fetch stage: PC, prioritised redirect mux and decoupling queue to ID
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_fetch_queue
   import if_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                IMEM_AW  = 6,
   parameter int                QDEPTH   = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      pc_write,
   input  logic                      jr,
   input  logic                      j,
   input  logic                      z,
   input  logic [ADDR_W-1:0]         jr_addr,
   input  logic [ADDR_W-1:0]         jump_addr,
   input  logic [ADDR_W-1:0]         branch_addr,
   output logic [IMEM_AW-1:0]        imem_addr,
   input  logic [DATA_W-1:0]         imem_data,
   output logic                      id_valid,
   input  logic                      id_ready,
   output logic [DATA_W-1:0]         id_instr,
   output logic [ADDR_W-1:0]         id_pc,
   output logic [ADDR_W-1:0]         id_next_pc,
   output logic [$clog2(QDEPTH):0]   q_count
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]               perf_fetch,
   output logic [31:0]               perf_full_stall,
   output logic [31:0]               perf_flush
`endif
);

   localparam int EW = DATA_W + 2 * ADDR_W;

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus;
   logic [ADDR_W-1:0] target;
   redir_sel_t        sel;
   logic              redirect;
   logic              pop;
   logic              push;
   logic              full;
   logic              empty;
   logic [EW-1:0]     head;

   assign pc_plus   = pc + ADDR_W'(PC_STEP);
   assign imem_addr = pc[IMEM_AW+1:2];
   assign redirect  = jr | j | z;
   assign id_valid  = ~empty;
   assign pop       = id_valid & id_ready;
   assign push      = pc_write & ~redirect & (~full | pop);

   always_comb begin
      sel = SEL_SEQ;
      if (jr)     sel = SEL_JR;
      else if (j) sel = SEL_J;
      else if (z) sel = SEL_BR;
   end

   always_comb begin
      target = pc_plus;
      case (sel)
         SEL_JR:  target = jr_addr;
         SEL_J:   target = jump_addr;
         SEL_BR:  target = branch_addr;
         default: target = pc_plus;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)         pc <= RESET_PC;
      else if (redirect) pc <= target;
      else if (push)     pc <= pc_plus;
   end

   // A pop coinciding with a redirect is void: the entry dies in the flush.
   if_fetch_fifo #(
      .DEPTH (QDEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop & ~redirect),
      .flush (redirect),
      .wdata ({imem_data, pc, pc_plus}),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (q_count)
   );

   assign {id_instr, id_pc, id_next_pc} = head;

`ifdef IF_PERF_CNT_EN
   logic stall;
   assign stall = pc_write & full & ~pop & ~redirect;

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetch      <= '0;
         perf_full_stall <= '0;
         perf_flush      <= '0;
      end else begin
         if (push && perf_fetch != '1)           perf_fetch      <= perf_fetch + 32'd1;
         if (stall && perf_full_stall != '1)     perf_full_stall <= perf_full_stall + 32'd1;
         if (redirect && perf_flush != '1)       perf_flush      <= perf_flush + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - self-checking bench for if_fetch_queue against a queue-based model
module tb_if_fetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        pc_write;
   logic        jr, j, z;
   logic [31:0] jr_addr, jump_addr, branch_addr;
   logic [5:0]  imem_addr;
   logic [31:0] imem_data;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr, id_pc, id_next_pc;
   logic [2:0]  q_count;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch, perf_full_stall, perf_flush;
`endif

   logic [31:0] rom [64];
   assign imem_data = rom[imem_addr];

   always #5 clk = ~clk;

   if_fetch_queue dut (
      .clk         (clk),
      .reset       (reset),
      .pc_write    (pc_write),
      .jr          (jr),
      .j           (j),
      .z           (z),
      .jr_addr     (jr_addr),
      .jump_addr   (jump_addr),
      .branch_addr (branch_addr),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_instr    (id_instr),
      .id_pc       (id_pc),
      .id_next_pc  (id_next_pc),
      .q_count     (q_count)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetch      (perf_fetch),
      .perf_full_stall (perf_full_stall),
      .perf_flush      (perf_flush)
`endif
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] mpc;
   int unsigned mfetch, mstall, mflush;
   int          ntests = 0;
   int          nfail  = 0;

   // One clock of the reference: decisions come from the inputs and model state before the edge.
   task automatic step();
      bit          redir, pop, push, full;
      logic [31:0] tgt;
      ent_t        e;
      redir = jr | j | z;
      tgt   = jr ? jr_addr : (j ? jump_addr : branch_addr);
      pop   = (mq.size() > 0) && id_ready;
      full  = (mq.size() == 4);
      push  = pc_write && !redir && (!full || pop);
      e.instr = rom[mpc[7:2]];
      e.pc    = mpc;
      @(posedge clk);
      if (reset) begin
         mq.delete();
         mpc = 32'h0;
         mfetch = 0; mstall = 0; mflush = 0;
      end else begin
         if (push) mfetch++;
         if (pc_write && full && !pop && !redir) mstall++;
         if (redir) begin
            mflush++;
            mq.delete();
            mpc = tgt;
         end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
               mq.push_back(e);
               mpc = mpc + 32'd4;
            end
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      reset = 1'b0; pc_write = 1'b1; id_ready = 1'b0;
      jr = 1'b0; j = 1'b0; z = 1'b0;
      jr_addr = 32'h0; jump_addr = 32'h0; branch_addr = 32'h0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      ntests++; if (id_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid got %0b want 0", id_valid); end
      ntests++; if (q_count !== 3'd0) begin nfail++; $display("FAIL reset_count got %0d want 0", q_count); end
      ntests++; if (imem_addr !== 6'd0) begin nfail++; $display("FAIL reset_imem_addr got %0h want 0", imem_addr); end
      ntests++; if ({id_instr, id_pc, id_next_pc} !== 96'h0) begin nfail++; $display("FAIL reset_head got %h/%h/%h want 0", id_instr, id_pc, id_next_pc); end
   endtask

   task automatic test_stream();
      do_reset();
      id_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         ntests++; if (id_valid !== 1'b1) begin nfail++; $display("FAIL stream_valid[%0d] got %0b want 1", k, id_valid); end
         ntests++; if (id_pc !== 32'(4 * (k - 1))) begin nfail++; $display("FAIL stream_pc[%0d] got %h want %h", k, id_pc, 32'(4 * (k - 1))); end
         ntests++; if (id_next_pc !== 32'(4 * k)) begin nfail++; $display("FAIL stream_next_pc[%0d] got %h want %h", k, id_next_pc, 32'(4 * k)); end
         ntests++; if (id_instr !== 32'(k - 1)) begin nfail++; $display("FAIL stream_instr[%0d] got %h want %h", k, id_instr, 32'(k - 1)); end
      end
      ntests++; if (q_count !== 3'd1) begin nfail++; $display("FAIL stream_count got %0d want 1", q_count); end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int k = 0; k < 6; k++) step();
      ntests++; if (q_count !== 3'd4) begin nfail++; $display("FAIL bp_count got %0d want 4", q_count); end
      ntests++; if (imem_addr !== 6'h4) begin nfail++; $display("FAIL bp_pc got %h want 4 (pc 0x10)", imem_addr); end
      ntests++; if (id_pc !== 32'h0) begin nfail++; $display("FAIL bp_head got %h want 0", id_pc); end
      id_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ntests++; if (id_valid !== 1'b1 || id_pc !== 32'(4 * i)) begin nfail++; $display("FAIL bp_order[%0d] got v=%0b pc=%h want pc %h", i, id_valid, id_pc, 32'(4 * i)); end
         step();
      end
   endtask

   task automatic test_redirect();
      id_ready = 1'b0;
      for (int k = 0; k < 5; k++) step();
      ntests++; if (q_count !== 3'd4) begin nfail++; $display("FAIL rd_fill got %0d want 4", q_count); end
      jr = 1'b1; j = 1'b1; z = 1'b1;
      jr_addr = 32'h40; jump_addr = 32'h80; branch_addr = 32'hC0;
      step();
      ntests++; if (q_count !== 3'd0 || id_valid !== 1'b0) begin nfail++; $display("FAIL rd_flush got count=%0d v=%0b want 0/0", q_count, id_valid); end
      jr = 1'b0; j = 1'b0; z = 1'b0;
      step();
      ntests++; if (id_pc !== 32'h40 || id_instr !== rom[16]) begin nfail++; $display("FAIL rd_jr got pc=%h instr=%h want 40/%h", id_pc, id_instr, rom[16]); end
      j = 1'b1; z = 1'b1;
      step();
      j = 1'b0; z = 1'b0;
      step();
      ntests++; if (id_pc !== 32'h80) begin nfail++; $display("FAIL rd_j got %h want 80", id_pc); end
      z = 1'b1;
      step();
      z = 1'b0;
      step();
      ntests++; if (id_pc !== 32'hC0) begin nfail++; $display("FAIL rd_z got %h want c0", id_pc); end
   endtask

   task automatic test_hold();
      do_reset();
      for (int k = 0; k < 3; k++) step();
      pc_write = 1'b0; id_ready = 1'b1;
      for (int k = 0; k < 4; k++) step();
      ntests++; if (q_count !== 3'd0 || id_valid !== 1'b0) begin nfail++; $display("FAIL hold_drain got count=%0d v=%0b want 0/0", q_count, id_valid); end
      ntests++; if (imem_addr !== 6'h3) begin nfail++; $display("FAIL hold_pc got %h want 3 (pc 0xc)", imem_addr); end
      z = 1'b1; branch_addr = 32'h24;
      step();
      ntests++; if (imem_addr !== 6'h9) begin nfail++; $display("FAIL hold_branch got %h want 9 (pc 0x24)", imem_addr); end
      z = 1'b0; pc_write = 1'b1;
      step();
      ntests++; if (id_pc !== 32'h24) begin nfail++; $display("FAIL hold_resume got %h want 24", id_pc); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int k = 0; k < 3; k++) step();
      jr = 1'b1; jr_addr = 32'h30; reset = 1'b1;
      step();
      ntests++; if (id_valid !== 1'b0 || q_count !== 3'd0) begin nfail++; $display("FAIL rmid_flush got v=%0b count=%0d want 0/0", id_valid, q_count); end
      ntests++; if (imem_addr !== 6'h0) begin nfail++; $display("FAIL rmid_pc got %h want 0", imem_addr); end
      jr = 1'b0; reset = 1'b0;
      step();
      ntests++; if (id_pc !== 32'h0) begin nfail++; $display("FAIL rmid_first got %h want 0", id_pc); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 64; i++) rom[i] = $urandom;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         reset       = ($urandom_range(0, 99) == 0);
         pc_write    = ($urandom_range(0, 9) < 8);
         id_ready    = ($urandom_range(0, 9) < 6);
         jr          = ($urandom_range(0, 19) == 0);
         j           = ($urandom_range(0, 19) == 0);
         z           = ($urandom_range(0, 14) == 0);
         jr_addr     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         jump_addr   = $urandom & 32'hFFFF_FFFC;
         branch_addr = $urandom & 32'hFFFF_FFFC;
         step();
         ntests++; if (id_valid !== (mq.size() > 0)) begin nfail++; $display("FAIL rnd_valid[%0d] got %0b want %0b", c, id_valid, mq.size() > 0); end
         ntests++; if (q_count !== 3'(mq.size())) begin nfail++; $display("FAIL rnd_count[%0d] got %0d want %0d", c, q_count, mq.size()); end
         ntests++; if (imem_addr !== mpc[7:2]) begin nfail++; $display("FAIL rnd_imem_addr[%0d] got %h want %h", c, imem_addr, mpc[7:2]); end
         if (mq.size() > 0) begin
            ntests++;
            if (id_pc !== mq[0].pc || id_next_pc !== mq[0].pc + 32'd4 || id_instr !== mq[0].instr) begin
               nfail++;
               $display("FAIL rnd_head[%0d] got %h/%h/%h want %h/%h/%h", c, id_instr, id_pc, id_next_pc, mq[0].instr, mq[0].pc, mq[0].pc + 32'd4);
            end
         end
      end
      idle_inputs();
   endtask

`ifdef IF_PERF_CNT_EN
   task automatic test_perf();
      do_reset();
      test_backpressure_counters();
   endtask

   task automatic test_backpressure_counters();
      for (int k = 0; k < 6; k++) step();
      ntests++; if (perf_full_stall !== 32'd2) begin nfail++; $display("FAIL perf_stall got %0d want 2", perf_full_stall); end
      ntests++; if (perf_fetch !== 32'd4) begin nfail++; $display("FAIL perf_fetch_fill got %0d want 4", perf_fetch); end
      jr = 1'b1; jr_addr = 32'h40;
      step();
      jr = 1'b0;
      ntests++; if (perf_flush !== 32'd1) begin nfail++; $display("FAIL perf_flush got %0d want 1", perf_flush); end
      id_ready = 1'b1;
      for (int k = 0; k < 5; k++) step();
      ntests++; if (perf_fetch !== mfetch || perf_full_stall !== mstall || perf_flush !== mflush) begin
         nfail++;
         $display("FAIL perf_model got %0d/%0d/%0d want %0d/%0d/%0d", perf_fetch, perf_full_stall, perf_flush, mfetch, mstall, mflush);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 32'(i);
      mpc = 32'h0; mfetch = 0; mstall = 0; mflush = 0;
      idle_inputs();
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_hold();
      test_reset_mid();
`ifdef IF_PERF_CNT_EN
      test_perf();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
